// File: rtl/bram_pkg.sv
// bram_pkg: shared state encoding, default sizes and lane slice helper for banked_block_ram.
package bram_pkg;
    localparam int DEF_DWIDTH    = 32;
    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_AWIDTH    = 9;
    localparam int DEF_MEM_SIZE  = 512;
    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
    function automatic int lane_lsb(input int lane, input int dwidth);
        return lane * dwidth;
    endfunction
endpackage

// File: rtl/bram_lane.sv
// bram_lane: one DWIDTH-bit lane with a single write port and two registered read ports.
module bram_lane #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 9,
    parameter int MEM_SIZE = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic              i_re0,
    input  logic              i_oor0,
    input  logic              i_byp0,
    input  logic [AWIDTH-1:0] i_raddr0,
    input  logic              i_re1,
    input  logic              i_oor1,
    input  logic [AWIDTH-1:0] i_raddr1,
    output logic [DWIDTH-1:0] o_q0,
    output logic [DWIDTH-1:0] o_q1
);
    (* ram_style = "block" *) logic [DWIDTH-1:0] r_mem [0:MEM_SIZE-1];
    logic [DWIDTH-1:0] r_q0, r_q1;
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    // Port 0 takes the incoming write data when the top flags a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q0 <= '0;
            r_q1 <= '0;
        end else begin
            if (i_re0) r_q0 <= i_oor0 ? '0 : (i_byp0 ? i_wdata : r_mem[i_raddr0]);
            if (i_re1) r_q1 <= i_oor1 ? '0 : r_mem[i_raddr1];
        end
    end
    assign o_q0 = r_q0;
    assign o_q1 = r_q1;
endmodule

// File: rtl/banked_block_ram.sv
// banked_block_ram: lane-banked dual-port RAM with post-reset clear, valid flags and write-first port-0 bypass.
// Define BANKED_BRAM_OUT_REG_EN to add an output register stage (read latency 2).
module banked_block_ram
    import bram_pkg::*;
#(
    parameter int DWIDTH         = DEF_DWIDTH,
    parameter int NUM_BANKS      = DEF_NUM_BANKS,
    parameter int AWIDTH         = DEF_AWIDTH,
    parameter int MEM_SIZE       = DEF_MEM_SIZE,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        init_done,
    input  logic [AWIDTH-1:0]           addr0,
    input  logic                        ce0,
    output logic [NUM_BANKS*DWIDTH-1:0] q0,
    output logic                        vld0,
    input  logic [AWIDTH-1:0]           addr1,
    input  logic                        ce1,
    input  logic                        we1,
    input  logic [NUM_BANKS-1:0]        be1,
    input  logic [NUM_BANKS*DWIDTH-1:0] d1,
    output logic [NUM_BANKS*DWIDTH-1:0] q1,
    output logic                        vld1
);
    localparam int              WW        = NUM_BANKS * DWIDTH;
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);
    localparam logic [AWIDTH:0]   SIZE_W    = (AWIDTH + 1)'(MEM_SIZE);
    state_t            r_state, w_state_nxt;
    logic [AWIDTH-1:0] r_cnt;
    logic              r_init_done, r_vld0, r_vld1;
    logic              w_clear, w_run, w_in0, w_in1, w_rd0, w_rd1, w_wr1, w_col;
    logic [AWIDTH-1:0] w_waddr;
    logic [WW-1:0]     w_q0, w_q1;
    assign w_clear = (r_state == ST_CLEAR);
    assign w_run   = r_init_done;
    assign w_in0   = {1'b0, addr0} < SIZE_W;
    assign w_in1   = {1'b0, addr1} < SIZE_W;
    assign w_rd0   = w_run & ce0;
    assign w_rd1   = w_run & ce1 & ~we1;
    assign w_wr1   = w_run & ce1 & we1 & w_in1;
    assign w_col   = w_rd0 & w_wr1 & (addr0 == addr1);
    assign w_waddr = w_clear ? r_cnt : addr1;
    always_comb begin
        w_state_nxt = (r_state == ST_CLEAR && r_cnt == LAST_ADDR) ? ST_RUN : r_state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_vld0      <= 1'b0;
            r_vld1      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_clear ? r_cnt + 1'b1 : r_cnt;
            r_init_done <= (w_state_nxt == ST_RUN);
            r_vld0      <= w_rd0;
            r_vld1      <= w_rd1;
        end
    end
    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_lane
        localparam int LSB = lane_lsb(i, DWIDTH);
        logic [DWIDTH-1:0] w_wdata;
        assign w_wdata = w_clear ? '0 : d1[LSB +: DWIDTH];
        bram_lane #(
            .DWIDTH  (DWIDTH),
            .AWIDTH  (AWIDTH),
            .MEM_SIZE(MEM_SIZE)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_we    (w_clear | (w_wr1 & be1[i])),
            .i_waddr (w_waddr),
            .i_wdata (w_wdata),
            .i_re0   (w_rd0),
            .i_oor0  (~w_in0),
            .i_byp0  (w_col & be1[i]),
            .i_raddr0(addr0),
            .i_re1   (w_rd1),
            .i_oor1  (~w_in1),
            .i_raddr1(addr1),
            .o_q0    (w_q0[LSB +: DWIDTH]),
            .o_q1    (w_q1[LSB +: DWIDTH])
        );
    end
    assign init_done = r_init_done;
`ifdef BANKED_BRAM_OUT_REG_EN
    logic [WW-1:0] r_q0_p, r_q1_p;
    logic          r_vld0_p, r_vld1_p;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q0_p   <= '0;
            r_q1_p   <= '0;
            r_vld0_p <= 1'b0;
            r_vld1_p <= 1'b0;
        end else begin
            r_q0_p   <= w_q0;
            r_q1_p   <= w_q1;
            r_vld0_p <= r_vld0;
            r_vld1_p <= r_vld1;
        end
    end
    assign q0   = r_q0_p;
    assign q1   = r_q1_p;
    assign vld0 = r_vld0_p;
    assign vld1 = r_vld1_p;
`else
    assign q0   = w_q0;
    assign q1   = w_q1;
    assign vld0 = r_vld0;
    assign vld1 = r_vld1;
`endif
endmodule

// File: tb/tb_banked_block_ram.sv
// tb_banked_block_ram: directed checks of clear, masked write, collision bypass and range protection.
module tb_banked_block_ram;
    localparam int AW = 9;
    localparam int WW = 128;
`ifdef BANKED_BRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [WW-1:0] D_MASK  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [WW-1:0] E_MASK  = 128'h00000000_CCCCCCCC_00000000_AAAAAAAA;
    localparam logic [WW-1:0] ONES1   = 128'h11111111_11111111_11111111_11111111;
    localparam logic [WW-1:0] TWOS    = 128'h22222222_22222222_22222222_22222222;
    localparam logic [WW-1:0] E_COL   = 128'h22222222_11111111_11111111_11111111;
    localparam logic [WW-1:0] ALL_F   = {WW{1'b1}};
    localparam logic [WW-1:0] PAT     = 128'h44444444_33333333_12345678_9ABCDEF0;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic          ce0 = 1'b0, ce1 = 1'b0, we1 = 1'b0;
    logic [3:0]    be1 = '0;
    logic [WW-1:0] d1 = '0;
    logic          init_done, vld0, vld1, init_done_s, vld0_s, vld1_s;
    logic [WW-1:0] q0, q1, q0_s, q1_s;
    int            checks = 0, errors = 0;

    always #5 clk = ~clk;

    banked_block_ram dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .addr0(addr0), .ce0(ce0), .q0(q0), .vld0(vld0),
        .addr1(addr1), .ce1(ce1), .we1(we1), .be1(be1), .d1(d1), .q1(q1), .vld1(vld1)
    );

    banked_block_ram #(.MEM_SIZE(300), .CLEAR_ON_RESET(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .init_done(init_done_s),
        .addr0(addr0), .ce0(ce0), .q0(q0_s), .vld0(vld0_s),
        .addr1(addr1), .ce1(ce1), .we1(we1), .be1(be1), .d1(d1), .q1(q1_s), .vld1(vld1_s)
    );

    task automatic do_write(input logic [AW-1:0] a, input logic [3:0] b, input logic [WW-1:0] d);
        @(negedge clk);
        ce1 = 1'b1; we1 = 1'b1; addr1 = a; be1 = b; d1 = d;
        @(negedge clk);
        ce1 = 1'b0; we1 = 1'b0; be1 = '0;
    endtask

    task automatic read_both(input logic [AW-1:0] a);
        @(negedge clk);
        ce0 = 1'b1; addr0 = a; ce1 = 1'b1; we1 = 1'b0; addr1 = a;
        @(negedge clk);
        ce0 = 1'b0; ce1 = 1'b0;
        repeat (LAT - 1) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b exp 0", init_done); end
        checks++; if (init_done_s !== 1'b0) begin errors++; $display("FAIL reset_init_done_s got %b exp 0", init_done_s); end
        checks++; if ({vld0, vld1} !== 2'b00) begin errors++; $display("FAIL reset_vld got %b exp 00", {vld0, vld1}); end
        checks++; if (q0 !== '0 || q1 !== '0) begin errors++; $display("FAIL reset_q got %h/%h exp 0", q0, q1); end
    endtask

    task automatic test_clear();
        int  n;
        logic saw_vld, s_first;
        saw_vld = 1'b0; s_first = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; ce0 = 1'b1; addr0 = '0;
        for (n = 1; n <= 600; n++) begin
            @(negedge clk);
            if (n == 1) s_first = init_done_s;
            saw_vld |= vld0;
            if (init_done === 1'b1) break;
        end
        ce0 = 1'b0;
        checks++; if (n != 512) begin errors++; $display("FAIL clear_cycles got %0d exp 512", n); end
        checks++; if (saw_vld !== 1'b0) begin errors++; $display("FAIL clear_ce0_ignored got vld0 %b exp 0", saw_vld); end
        checks++; if (s_first !== 1'b1) begin errors++; $display("FAIL noclear_init_done got %b exp 1", s_first); end
    endtask

    task automatic test_read_zero();
        read_both(9'd37);
        checks++; if (q0 !== '0 || vld0 !== 1'b1) begin errors++; $display("FAIL read37 got q0 %h vld0 %b exp 0/1", q0, vld0); end
        checks++; if (q1 !== '0 || vld1 !== 1'b1) begin errors++; $display("FAIL read37_p1 got q1 %h vld1 %b exp 0/1", q1, vld1); end
    endtask

    task automatic test_masked_write();
        do_write(9'd5, 4'b0101, D_MASK);
        checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL write_vld1 got %b exp 0", vld1); end
        read_both(9'd5);
        checks++; if (q0 !== E_MASK) begin errors++; $display("FAIL masked_q0 got %h exp %h", q0, E_MASK); end
        checks++; if (q1 !== E_MASK) begin errors++; $display("FAIL masked_q1 got %h exp %h", q1, E_MASK); end
        @(negedge clk);
        checks++; if (vld0 !== 1'b0 || q0 !== E_MASK) begin errors++; $display("FAIL hold_q0 got %h vld0 %b exp %h/0", q0, vld0, E_MASK); end
    endtask

    task automatic test_collision();
        do_write(9'd9, 4'hF, ONES1);
        @(negedge clk);
        ce0 = 1'b1; addr0 = 9'd9; ce1 = 1'b1; we1 = 1'b1; addr1 = 9'd9; be1 = 4'b1000; d1 = TWOS;
        @(negedge clk);
        ce0 = 1'b0; ce1 = 1'b0; we1 = 1'b0; be1 = '0;
        repeat (LAT - 1) @(negedge clk);
        checks++; if (q0 !== E_COL || vld0 !== 1'b1) begin errors++; $display("FAIL collision_q0 got %h vld0 %b exp %h/1", q0, vld0, E_COL); end
        checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL collision_vld1 got %b exp 0", vld1); end
        read_both(9'd9);
        checks++; if (q1 !== E_COL) begin errors++; $display("FAIL after_collision_q1 got %h exp %h", q1, E_COL); end
    endtask

    task automatic test_be_zero();
        do_write(9'd9, 4'b0000, ALL_F);
        read_both(9'd9);
        checks++; if (q0 !== E_COL) begin errors++; $display("FAIL be_zero_q0 got %h exp %h", q0, E_COL); end
    endtask

    task automatic test_out_of_range();
        do_write(9'd299, 4'hF, PAT);
        do_write(9'd400, 4'hF, ALL_F);
        read_both(9'd400);
        checks++; if (q0_s !== '0 || vld0_s !== 1'b1) begin errors++; $display("FAIL oor_q0 got %h vld0 %b exp 0/1", q0_s, vld0_s); end
        checks++; if (q1_s !== '0 || vld1_s !== 1'b1) begin errors++; $display("FAIL oor_q1 got %h vld1 %b exp 0/1", q1_s, vld1_s); end
        checks++; if (q0 !== ALL_F) begin errors++; $display("FAIL inrange_400_q0 got %h exp %h", q0, ALL_F); end
        read_both(9'd299);
        checks++; if (q0_s !== PAT) begin errors++; $display("FAIL addr299_q0 got %h exp %h", q0_s, PAT); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (q0 !== '0 || init_done !== 1'b0) begin errors++; $display("FAIL async_reset got q0 %h init %b exp 0/0", q0, init_done); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL mid_clear_init got %b exp 0", init_done); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (n = 1; n <= 600; n++) begin
            @(negedge clk);
            if (init_done === 1'b1) break;
        end
        checks++; if (n != 512) begin errors++; $display("FAIL restart_cycles got %0d exp 512", n); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_read_zero();
        test_masked_write();
        test_collision();
        test_be_zero();
        test_out_of_range();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/banked_block_ram.md
Name: banked_block_ram

Overview:
- Parametrised dual-port block RAM for feature-map and weight buffering in the MobileNetV1 accelerator.
- Memory is split into NUM_BANKS lanes of DWIDTH bits. Port 0 is read-only; port 1 is read/write with per-lane write enables.
- Adds a post-reset clear engine, valid flags on both ports, port-0 read-after-write bypass, and out-of-range address protection.

Parameters:
- DWIDTH, 32, bits per lane
- NUM_BANKS, 4, lanes per word; word width = NUM_BANKS*DWIDTH
- AWIDTH, 9, address width
- MEM_SIZE, 512, words per lane; must be <= 2**AWIDTH
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = skip the clear pass

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- init_done  out  1  high once the RAM accepts accesses
- addr0  in  AWIDTH  port-0 read address
- ce0  in  1  port-0 read request
- q0  out  NUM_BANKS*DWIDTH  port-0 read data
- vld0  out  1  q0 updated this cycle
- addr1  in  AWIDTH  port-1 address
- ce1  in  1  port-1 enable
- we1  in  1  port-1 write (1) / read (0)
- be1  in  NUM_BANKS  per-lane write enable; bit i selects d1[i*DWIDTH +: DWIDTH]
- d1  in  NUM_BANKS*DWIDTH  port-1 write data
- q1  out  NUM_BANKS*DWIDTH  port-1 read data
- vld1  out  1  q1 updated this cycle

Behaviour:
- Reset (asynchronous, rst_n low):
  - q0, q1 = 0; vld0, vld1 = 0; init_done = 0; clear counter = 0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else RUN.
  - RAM contents are not reset directly.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle writes 0 to all lanes at the counter address, then increments the counter. After writing address MEM_SIZE-1, moves to RUN; clear takes exactly MEM_SIZE cycles.
  - CLEAR: ce0 and ce1 are ignored; vld0 = vld1 = 0; q0 and q1 hold their values.
  - RUN: init_done = 1; no exit except reset.
  - Reset asserted mid-CLEAR: counter returns to 0 and the clear restarts after release.
  - CLEAR_ON_RESET=0: init_done rises on the first clk edge after rst_n deasserts.
- Port-0 read (RUN, ce0=1):
  - q0 = ram[addr0] one cycle later; vld0 = 1 for exactly that cycle.
  - ce0=0: q0 holds; vld0 = 0 next cycle.
- Port-1 (RUN, ce1=1):
  - we1=1: writes lanes with be1[i]=1 and leaves other lanes unchanged. q1 holds; vld1 = 0.
  - we1=0: q1 = ram[addr1] next cycle; vld1 = 1.
  - we1=1 with be1=0: no-op, treated as a write (vld1 = 0).
- Collision, port-0 read and port-1 write to the same address in the same cycle: q0 returns the new data for enabled lanes and the old data for disabled lanes (write-first bypass).
- Out-of-range address (addr >= MEM_SIZE):
  - Read returns 0 with the valid flag still asserted.
  - Write is dropped.
- Width rule: lane i occupies bits [i*DWIDTH +: DWIDTH] of every word-wide bus.
- Storage carries the block-RAM style attribute; there is one array per lane.

Optional Feature:
- Macro: BANKED_BRAM_OUT_REG_EN.
- Defined:
  - Adds one output register stage on both ports; read latency becomes 2 cycles.
  - vld0 and vld1 are delayed together with q0 and q1.
  - Pipeline registers reset to 0.
  - The collision bypass is evaluated at stage 1.
- Undefined: latency is 1 cycle as described above.

Decomposition:
- Shared package (bram_pkg):
  - FSM state encoding (ST_CLEAR, ST_RUN).
  - Function computing the lane slice index.
  - Default width constants.
- Sub-module bram_lane: one DWIDTH-bit dual-port lane holding the array, the per-lane write, and the two read registers. Instantiated NUM_BANKS times with a generate loop.
- Top level keeps the clear FSM, range check, bypass muxing and valid flags.

Test Plan:
- Reset, defaults, CLEAR_ON_RESET=1: release rst_n -> init_done stays 0 for 512 cycles, then 1. Read address 37 afterwards -> q0 = 0, vld0 = 1.
- Lane-masked write: write d1 = 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA to address 5 with be1 = 4'b0101 over zeroed memory, then read on both ports -> q0 = q1 = 0x00000000_CCCCCCCC_00000000_AAAAAAAA.
- Collision: preload address 9 with all 0x11111111. Same cycle: ce0 read address 9, port-1 write 0x2222… with be1 = 4'b1000 -> q0 top lane = 0x22222222, other lanes = 0x11111111.
- Out of range, MEM_SIZE=300, AWIDTH=9: write 0xFFFF… to address 400, then read address 400 -> q0 = 0, vld0 = 1. Address 299 is unaffected.
- Reset mid-clear: pulse rst_n low at clear cycle 200 -> init_done first rises exactly 512 cycles after the second release.
- Macro on (BANKED_BRAM_OUT_REG_EN): ce0 pulse at cycle t -> vld0 high only at t+2 with correct data. With ce0 low, vld0 = 0 and q0 holds.
